// File: rtl/bus_pkg.sv
// Shared types and widths for the system memory bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    localparam int M_CPU = 0;
    localparam int M_DMA = 1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester-side and memory-side signals of the two-master bus arbiter.
interface bus_arbiter_if;
    import bus_pkg::*;

    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] adress_bus;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              r;
    logic              w;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, rd_data,
        output ack, rdata, grant, adress_bus, wr_data, r, w
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, rd_data,
        input  ack, rdata, grant, adress_bus, wr_data, r, w
    );

endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the 8-bit memory bus; req-to-ack is WAIT_CYCLES+2 cycles.
// Requesters hold req until their ack pulse; req is only sampled while idle.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("bus_arbiter: WAIT_CYCLES must be in 0..15");
    end

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel;
    logic [1:0]        owner_oh;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        sel     = last_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    // On a tie the master that did not win last time goes first.
                    sel     = (bus.req == 2'b11) ? ~last_q : bus.req[M_DMA];
                    owner_d = sel;
                    last_d  = sel;
                    we_d    = bus.we[sel];
                    addr_d  = sel ? bus.addr1  : bus.addr0;
                    wdata_d = sel ? bus.wdata1 : bus.wdata0;
                    cnt_d   = WAIT_LD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = bus.rd_data;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign owner_oh       = 2'b01 << owner_q;
    assign bus.grant      = (state_q == IDLE) ? 2'b00 : owner_oh;
    assign bus.ack        = (state_q == ACK) ? owner_oh : 2'b00;
    assign bus.r          = (state_q == ACCESS) && !we_q;
    assign bus.w          = (state_q == ACCESS) && we_q;
    assign bus.adress_bus = addr_q;
    assign bus.wr_data    = wdata_q;
    assign bus.rdata      = rdata_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and sequencer for the 8-bit system memory bus (16-bit address). It sits between the memory/peripheral bus and two requesters: master 0 (CPU fetch/load/store) and master 1 (DMA/video). It grants the bus round-robin, drives the address, data and strobes for a fixed-length access, and returns read data with a one-cycle acknowledge. The tristate date_bus is resolved at top level; this block uses separate read and write data paths.

## Interface
- WAIT_CYCLES, 1: extra cycles the strobe is held beyond the first access cycle (legal 0..15).
- clk  in  1: system clock; all state updates on rising edge.
- reset  in  1: synchronous, active-high.
- req  in  2: per-master request; bit i = master i.
- we  in  2: per-master write enable (1 = write, 0 = read), qualified by req.
- addr0, addr1  in  16: per-master address.
- wdata0, wdata1  in  8: per-master write data.
- ack  out  2: one-cycle completion pulse per master.
- rdata  out  8: read data, shared by both masters, valid while any ack bit is high.
- grant  out  2: one-hot owner of the current transaction; 0 when idle.
- adress_bus  out  16: memory address.
- wr_data  out  8: memory write data.
- rd_data  in  8: memory read data.
- r, w  out  1: read and write strobes, mutually exclusive.

## Operation
- **States:** IDLE, ACCESS, ACK.
- **IDLE**
  - Both outputs idle: grant = 0, r = w = 0.
  - If any req bit is high, select a master and go to ACCESS.
  - If both request, pick the master other than `last`; if one requests, pick it.
  - Register the selected master's addr, wdata and we, set `last` to that master, and load wait counter = WAIT_CYCLES.
- **ACCESS**
  - Drive adress_bus and wr_data from the latched values, and assert r or w per the latched we. Assert grant.
  - When the counter is 0: if reading, capture rd_data into rdata, then go to ACK. Otherwise decrement.
- **ACK**
  - Strobes low. Pulse ack[owner] for exactly one cycle; grant stays on the owner. Go to IDLE.
  - req is ignored in this state.
- **Requester rules**
  - Hold req, we, addr and wdata stable from assertion until ack is seen.
  - Drop req in the cycle ack is sampled high. A req still high in IDLE starts a new transaction.
- **Latched-value rule:** changes to addr or wdata after grant have no effect on the current transaction.
- **rdata**
  - Holds the last read value until the next read completes.
  - After a write, rdata is unchanged.
- **Counter:** 4 bits. WAIT_CYCLES > 15 is illegal and is flagged by an elaboration-time check.

## Timing
- **Reset values:** state = IDLE, grant = 0, ack = 0, r = 0, w = 0, adress_bus = 0, wr_data = 0, rdata = 0, last = 1 (so master 0 wins the first tie).
- **Cycle-level sequence:** req sampled at edge k → ACCESS from edge k+1 (strobe visible in cycle k+1) → strobe held WAIT_CYCLES+1 cycles → ack high for one cycle → IDLE.
- **Latency:** req-to-ack = WAIT_CYCLES + 2 cycles. Back-to-back throughput is one access per WAIT_CYCLES + 3 cycles.
- **Read capture:** rd_data is sampled on the last ACCESS edge, so memory must present data within WAIT_CYCLES + 1 cycles of the strobe.
- **Simultaneous requests:** round-robin alternates strictly. A master requesting continuously cannot win twice in a row while the other is waiting.
- **Reset mid-operation:** in the cycle after reset is sampled, r and w are low, grant and ack are 0, and no ack is issued for the aborted transaction; the requester must reissue.
- **Request withdrawn:** a req dropped after grant does not abort the transaction; it completes and acks.

## Structure
- **Shared package `bus_pkg`:**
  - state enum: IDLE, ACCESS, ACK
  - ADDR_W = 16, DATA_W = 8
  - master index constants: M_CPU = 0, M_DMA = 1
- **Sub-modules:** none. Arbitration is a few lines inside the FSM; a separate sub-module is unnecessary.

## Test plan
- **Single read:** WAIT_CYCLES = 1, master 0 reads 0x2000, memory returns 0xA5 → r high 2 cycles, ack[0] pulses 3 cycles after req sampled, rdata = 0xA5, w never high.
- **Single write:** master 1 writes 0x5A to 0x8001 → w high with adress_bus = 0x8001 and wr_data = 0x5A, ack[1] once, rdata unchanged.
- **Contention:** both masters request continuously for 4 transactions from reset → grant order 0, 1, 0, 1, and ack never goes to both masters at once.
- **WAIT_CYCLES = 0:** read of 0x0010 → strobe 1 cycle, ack 2 cycles after sampling.
- **Reset mid-access:** reset asserted during ACCESS → next cycle r = w = 0, grant = 0, no ack; re-requesting completes normally.
- **Held request:** master 0 keeps req high after ack with master 1 idle → a second transaction starts after one IDLE cycle.
